// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// DMEM_MISALIGN_TRAP_EN is consumed by data_mem_responder, not here.
package dmem_pkg;

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Access width in bytes; funct3[2] only selects the load extension.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store byte enables and load extract/extend.
// Both paths take data right-aligned at the access index.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] raw,
  output logic [7:0]  be,
  output logic [63:0] rdata
);

  always_comb begin
    be = 8'h00;
    unique case (funct3[1:0])
      F3_B[1:0]: be = 8'h01;
      F3_H[1:0]: be = 8'h03;
      F3_W[1:0]: be = 8'h0f;
      default:   be = 8'hff;
    endcase
  end

  // funct3[2] set means zero-extend; 111 falls into the full 64-bit case.
  always_comb begin
    rdata = raw;
    unique case (funct3[1:0])
      2'b00: rdata = funct3[2] ? {56'b0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
      2'b01: rdata = funct3[2] ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      2'b10: rdata = funct3[2] ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory with fixed response latency and pipeline stall.
// Optional: define DMEM_MISALIGN_TRAP_EN to flag misaligned / funct3==111 accesses via rsp_err.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        stall_o,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_e         state_q;
  logic [CW-1:0]  cnt_q;

  logic           lat_write;
  logic [2:0]     lat_funct3;
  logic [IW-1:0]  lat_idx;
  logic [63:0]    lat_wdata;

  logic [7:0]     mem [DEPTH_BYTES];

  logic           accept;
  logic           complete;
  logic           trap;
  logic           acc_write;
  logic [2:0]     acc_funct3;
  logic [IW-1:0]  acc_idx;
  logic [63:0]    acc_wdata;
  logic [63:0]    raw;
  logic [63:0]    load_data;
  logic [7:0]     be;

  // Address bits above the storage index are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:IW];

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready;
  assign stall_o   = (state_q == StBusy) | accept;

  // With LATENCY==1 the access completes on the accept edge straight from the request bus.
  assign acc_write  = (state_q == StBusy) ? lat_write  : req_write;
  assign acc_funct3 = (state_q == StBusy) ? lat_funct3 : req_funct3;
  assign acc_idx    = (state_q == StBusy) ? lat_idx    : req_addr[IW-1:0];
  assign acc_wdata  = (state_q == StBusy) ? lat_wdata  : req_wdata;

  always_comb begin
    complete = 1'b0;
    if (LATENCY == 1) begin
      complete = accept;
    end else begin
      complete = (state_q == StBusy) && (cnt_q == CW'(1));
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [3:0] acc_size;
  assign acc_size = size_bytes(acc_funct3);
  assign trap = ((acc_idx[2:0] & acc_size[2:0] - 3'd1) != 3'b000) || (acc_funct3 == 3'b111);
`else
  assign trap = 1'b0;
`endif

  // Index arithmetic at IW bits gives the wrap past the top of storage for free.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 8; i++) begin
      raw[8*i +: 8] = mem[acc_idx + IW'(i)];
    end
  end

  dmem_lane_align u_lane_align (
    .funct3 (acc_funct3),
    .raw    (raw),
    .be     (be),
    .rdata  (load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset && complete && acc_write && !trap) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) begin
          mem[acc_idx + IW'(i)] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_write  <= req_write;
      lat_funct3 <= req_funct3;
      lat_idx    <= req_addr[IW-1:0];
      lat_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete;
      rsp_err   <= complete & trap;
      rsp_rdata <= (complete && !acc_write && !trap) ? load_data : '0;
      unique case (state_q)
        StIdle: begin
          if (accept && (LATENCY > 1)) begin
            state_q <= StBusy;
            cnt_q   <= CW'(LATENCY - 1);
          end
        end
        StBusy: begin
          if (complete) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid1 = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;

  logic        req_ready, stall_o, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        req_ready1, stall1, rsp_valid1, rsp_err1;
  logic [63:0] rsp_rdata1;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall_o(stall_o), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready1), .stall_o(stall1), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  // Reference: one transaction applied to a flat byte array.
  task automatic model_access(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wd, output logic [63:0] rd, output logic err);
    int size, idx, sh;
    logic [63:0] val;
    size = 1 << f3[1:0];
    idx  = int'(addr % DEPTH);
    rd   = '0;
    err  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr % size) != 0 || f3 == 3'b111) begin
      err = 1'b1;
      return;
    end
`endif
    if (w) begin
      for (int i = 0; i < size; i++) model_mem[(idx + i) % DEPTH] = wd[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < size; i++) val |= 64'(model_mem[(idx + i) % DEPTH]) << (8 * i);
      if (size == 8 || f3[2]) begin
        rd = val;
      end else begin
        sh = 64 - 8 * size;
        rd = 64'($signed(val << sh) >>> sh);
      end
    end
  endtask

  // One transaction on the LATENCY=2 instance; lat counts cycles from acceptance to rsp_valid.
  task automatic xact(input logic w, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wd, output logic [63:0] rd, output logic err,
                      output int lat);
    @(negedge clk);
    req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    rd  = rsp_rdata;
    err = rsp_err;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    if (rsp_rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rsp_err); end
    if (req_ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready_l1 got=%b exp=1", req_ready1); end
    reset = 1'b0;
  endtask

  task automatic test_fill;
    logic [63:0] rd, erd, wd;
    logic err, eerr;
    int lat;
    for (int s = 0; s < DEPTH / 8; s++) begin
      wd = {$urandom, $urandom};
      model_access(1'b1, 3'b011, 64'(s * 8), wd, erd, eerr);
      xact(1'b1, 3'b011, 64'(s * 8), wd, rd, err, lat);
      checks += 2;
      if (lat !== 2) begin failures++; $display("FAIL fill_latency slot=%0d got=%0d exp=2", s, lat); end
      if (rd !== erd || err !== eerr) begin
        failures++; $display("FAIL fill_rsp slot=%0d got=%h/%b exp=%h/%b", s, rd, err, erd, eerr);
      end
    end
  endtask

  task automatic test_directed;
    logic [63:0] rd, erd;
    logic err, eerr;
    int lat;
    logic [2:0]  f3s  [6] = '{3'b011, 3'b000, 3'b100, 3'b001, 3'b010, 3'b011};
    logic [63:0] adrs [6] = '{64'h10, 64'h10, 64'h10, 64'h16, 64'h14, 64'(DEPTH + 'h10)};
    logic [63:0] exps [6] = '{64'h1122334455667788, 64'hFFFFFFFFFFFFFF88, 64'h88,
                              64'h1122, 64'h11223344, 64'h1122334455667788};
    model_access(1'b1, 3'b011, 64'h10, 64'h1122334455667788, erd, eerr);
    xact(1'b1, 3'b011, 64'h10, 64'h1122334455667788, rd, err, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL sd_latency got=%0d exp=2", lat); end
    for (int i = 0; i < 6; i++) begin
      xact(1'b0, f3s[i], adrs[i], 64'h0, rd, err, lat);
      checks += 2;
      if (rd !== exps[i]) begin
        failures++; $display("FAIL directed_load%0d got=%h exp=%h", i, rd, exps[i]);
      end
      if (lat !== 2) begin failures++; $display("FAIL directed_latency%0d got=%0d exp=2", i, lat); end
    end
    // Store straddling the top of storage, read back from both ends.
    model_access(1'b1, 3'b010, 64'(DEPTH - 2), 64'hDEADBEEF, erd, eerr);
    xact(1'b1, 3'b010, 64'(DEPTH - 2), 64'hDEADBEEF, rd, err, lat);
    checks++;
    if (err !== eerr) begin failures++; $display("FAIL wrap_store_err got=%b exp=%b", err, eerr); end
    model_access(1'b0, 3'b101, 64'h0, 64'h0, erd, eerr);
    xact(1'b0, 3'b101, 64'h0, 64'h0, rd, err, lat);
    checks++;
    if (rd !== erd) begin failures++; $display("FAIL wrap_low got=%h exp=%h", rd, erd); end
    model_access(1'b0, 3'b101, 64'(DEPTH - 2), 64'h0, erd, eerr);
    xact(1'b0, 3'b101, 64'(DEPTH - 2), 64'h0, rd, err, lat);
    checks++;
    if (rd !== erd) begin failures++; $display("FAIL wrap_high got=%h exp=%h", rd, erd); end
  endtask

  // Request held high across two acceptances; expected waveform derived per cycle.
  task automatic test_timing(input int l);
    logic reqv, busy, e_ready, e_stall, e_rsp, o_ready, o_stall, o_rsp;
    req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h10; req_wdata = '0;
    for (int c = 0; c <= 2 * l + 1; c++) begin
      @(negedge clk);
      reqv = (c <= l);
      if (l == 1) req_valid1 = reqv; else req_valid = reqv;
      #1;
      busy    = (c >= 1 && c <= l - 1) || (c >= l + 1 && c <= 2 * l - 1);
      e_ready = !busy;
      e_stall = busy || (reqv && e_ready);
      e_rsp   = (c == l) || (c == 2 * l);
      o_ready = (l == 1) ? req_ready1 : req_ready;
      o_stall = (l == 1) ? stall1 : stall_o;
      o_rsp   = (l == 1) ? rsp_valid1 : rsp_valid;
      checks += 3;
      if (o_ready !== e_ready) begin
        failures++; $display("FAIL timing_ready L=%0d cyc=%0d got=%b exp=%b", l, c, o_ready, e_ready);
      end
      if (o_stall !== e_stall) begin
        failures++; $display("FAIL timing_stall L=%0d cyc=%0d got=%b exp=%b", l, c, o_stall, e_stall);
      end
      if (o_rsp !== e_rsp) begin
        failures++; $display("FAIL timing_rsp L=%0d cyc=%0d got=%b exp=%b", l, c, o_rsp, e_rsp);
      end
    end
    req_valid = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [63:0] rd, erd;
    logic err, eerr, seen;
    int lat;
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b011; req_addr = 64'h10;
    req_wdata = 64'hAAAAAAAAAAAAAAAA; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_rsp got=%b exp=0", seen); end
    model_access(1'b0, 3'b011, 64'h10, 64'h0, erd, eerr);
    xact(1'b0, 3'b011, 64'h10, 64'h0, rd, err, lat);
    checks++;
    if (rd !== erd) begin failures++; $display("FAIL abort_data got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_random;
    logic [63:0] rd, erd, addr, wd;
    logic err, eerr, w;
    logic [2:0] f3;
    int lat;
    for (int n = 0; n < 120; n++) begin
      w    = 1'($urandom_range(0, 1));
      f3   = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      wd   = {$urandom, $urandom};
      model_access(w, f3, addr, wd, erd, eerr);
      xact(w, f3, addr, wd, rd, err, lat);
      checks += 3;
      if (rd !== erd) begin
        failures++; $display("FAIL rand_rdata n=%0d w=%b f3=%0d a=%h got=%h exp=%h",
                             n, w, f3, addr, rd, erd);
      end
      if (err !== eerr) begin failures++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, err, eerr); end
      if (lat !== 2) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=2", n, lat); end
    end
  endtask

`ifdef DMEM_MISALIGN_TRAP_EN
  task automatic test_trap;
    logic [63:0] rd, erd, before;
    logic err, eerr;
    int lat;
    xact(1'b0, 3'b010, 64'h12, 64'h0, rd, err, lat);
    checks += 2;
    if (err !== 1'b1) begin failures++; $display("FAIL trap_lw_err got=%b exp=1", err); end
    if (rd !== 64'h0) begin failures++; $display("FAIL trap_lw_rdata got=%h exp=0", rd); end
    model_access(1'b0, 3'b011, 64'h10, 64'h0, before, eerr);
    xact(1'b1, 3'b010, 64'h12, 64'h55555555, rd, err, lat);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL trap_sw_err got=%b exp=1", err); end
    xact(1'b0, 3'b011, 64'h10, 64'h0, rd, err, lat);
    checks++;
    if (rd !== before) begin failures++; $display("FAIL trap_sw_store got=%h exp=%h", rd, before); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_timing(2);
    test_timing(1);
    test_reset_abort();
`ifdef DMEM_MISALIGN_TRAP_EN
    test_trap();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
